// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage data-memory request FSM with load capture, stall counting and PC redirect.
module mem_stage_ctrl #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              memtoReg_MEM,
  input  logic              memWr_MEM,
  input  logic [WORD_W-1:0] Output_Port_MEM,
  input  logic [WORD_W-1:0] storedata_MEM,
  input  logic [1:0]        PC_Src_MEM,
  input  logic              zero_MEM,
  input  logic [WORD_W-1:0] branch_addr_MEM,
  input  logic [WORD_W-1:0] jump_addr_MEM,
  input  logic [WORD_W-1:0] busA_MEM,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              exmem_enable,
  output logic              exmem_flush,
  output logic              front_flush,
  output logic              pc_redirect,
  output logic [WORD_W-1:0] pc_target,
  output logic [WORD_W-1:0] loaddata_WB,
  output logic [CNT_W-1:0]  stall_cnt
);
  typedef enum logic {IDLE, DONE} state_t;
  state_t            state_q, state_d;
  logic [WORD_W-1:0] loaddata_q, loaddata_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              req, redirect_raw;
  logic [WORD_W-1:0] target_raw;
  always_comb begin
    // nRST gates the request so a reset mid-access drops it without waiting for a clock
    req          = nRST && state_q == IDLE && (memtoReg_MEM || memWr_MEM);
    dmemWEN      = req && memWr_MEM;
    dmemREN      = req && !memWr_MEM;
    dmemaddr     = req ? Output_Port_MEM : '0;
    dmemstore    = req ? storedata_MEM : '0;
    exmem_enable = !req;
    state_d      = (req && dhit) ? DONE : IDLE;
    loaddata_d   = (dmemREN && dhit) ? dmemload : loaddata_q;
    stall_cnt_d  = (req && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    redirect_raw = (PC_Src_MEM == 2'b01 && zero_MEM) || PC_Src_MEM[1];
    target_raw   = PC_Src_MEM == 2'b11 ? busA_MEM :
                   PC_Src_MEM == 2'b10 ? jump_addr_MEM :
                   (PC_Src_MEM == 2'b01 && zero_MEM) ? branch_addr_MEM : '0;
    pc_redirect  = redirect_raw && exmem_enable;
    pc_target    = pc_redirect ? target_raw : '0;
    exmem_flush  = pc_redirect;
    front_flush  = pc_redirect;
    loaddata_WB  = loaddata_q;
    stall_cnt    = stall_cnt_q;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      loaddata_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      loaddata_q  <= loaddata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller sitting downstream of the EX/MEM pipeline register. It consumes the MEM-stage control and data fields and issues data-memory requests to the cache/memory port. It stalls the pipeline through the EX/MEM `enable` input until the access completes and captures load data for writeback. It also resolves branch/jump redirects and drives the EX/MEM `flush` and front-end flush.

## Interface
Parameters:
- `WORD_W`, 32, data/address width
- `CNT_W`, 16, width of the stall-cycle performance counter

Ports (one clock `CLK`; reset `nRST` is asynchronous and active-low):
- `CLK`  in  1  system clock, all state updates on rising edge
- `nRST`  in  1  asynchronous active-low reset
- `memtoReg_MEM`  in  1  instruction in MEM is a load
- `memWr_MEM`  in  1  instruction in MEM is a store
- `Output_Port_MEM`  in  WORD_W  ALU result, used as data address
- `storedata_MEM`  in  WORD_W  store data
- `PC_Src_MEM`  in  2  00 sequential, 01 BEQ, 10 jump, 11 jump-register
- `zero_MEM`  in  1  ALU zero flag
- `branch_addr_MEM`, `jump_addr_MEM`, `busA_MEM`  in  WORD_W each  redirect targets
- `dhit`  in  1  memory port completes current request this cycle
- `dmemload`  in  WORD_W  load data, valid when `dhit`
- `dmemREN`, `dmemWEN`  out  1 each  read / write request
- `dmemaddr`, `dmemstore`  out  WORD_W each  request address / store data
- `exmem_enable`  out  1  drives EX/MEM `enable` (0 = hold)
- `exmem_flush`  out  1  drives EX/MEM `flush`
- `front_flush`  out  1  flushes IF/ID and ID/EX
- `pc_redirect`  out  1  PC must load `pc_target`
- `pc_target`  out  WORD_W  redirect address
- `loaddata_WB`  out  WORD_W  registered load data
- `stall_cnt`  out  CNT_W  saturating count of stalled cycles

## Operation
- A memory op is present when `memtoReg_MEM | memWr_MEM`. If both are set, the access is a write: WEN=1 and REN=0.
- The FSM has two states, IDLE and DONE.
- IDLE with no memory op:
  - REN=WEN=0, `exmem_enable`=1.
  - The FSM stays in IDLE.
- IDLE with a memory op:
  - Requests are asserted combinationally. `dmemaddr`=`Output_Port_MEM`, `dmemstore`=`storedata_MEM`.
  - `exmem_enable`=0.
  - If `dhit`=0, the FSM stays in IDLE and requests and addresses hold steady.
  - If `dhit`=1, the FSM goes to DONE. For a read, `dmemload` is latched into `loaddata_WB`.
- DONE:
  - Requests are 0 and `exmem_enable`=1, so the pipeline advances on this edge.
  - The FSM goes to IDLE unconditionally. This guarantees no re-issue of the completed op.
- Redirect (combinational from MEM fields):
  - 01 with `zero_MEM`=1 selects `branch_addr_MEM`.
  - 10 selects `jump_addr_MEM`.
  - 11 selects `busA_MEM`.
  - 01 with zero=0, and 00, give no redirect.
  - `pc_target` is 0 when there is no redirect.
- `exmem_flush` = `front_flush` = `pc_redirect`. These are gated by `exmem_enable` so that a flush never coincides with a hold.
- `stall_cnt` increments on every cycle with `exmem_enable`=0 and saturates at all-ones.
- `dmemaddr`/`dmemstore` are 0 when no request is asserted.

## Timing
- Reset values (async, immediate on `nRST`=0):
  - FSM = IDLE, `loaddata_WB`=0, `stall_cnt`=0.
  - With MEM inputs zero, all combinational outputs are 0 except `exmem_enable`=1.
- Minimum memory op: 2 cycles in MEM, with 1 stall cycle. Each extra cycle without `dhit` adds one stall cycle.
- `loaddata_WB` is valid from the edge that enters DONE. It holds until the next load hit.
- A non-memory instruction spends 1 cycle in MEM with no stall.
- Redirect and flush take effect in the same cycle the branch/jump occupies MEM (0-cycle decision latency).
- `dhit` seen while no request is asserted (IDLE without an op, or DONE) is ignored: no state change, no latch.
- Reset mid-access drops the requests immediately and returns to IDLE. The partial access is not retried by this block.

## Test plan
- Reset with all inputs 0 -> REN=WEN=0, `exmem_enable`=1, `loaddata_WB`=0, `stall_cnt`=0.
- Load at addr 0x40 with `dhit` high in the first cycle, `dmemload`=0xDEADBEEF -> REN=1 and enable=0 for 1 cycle. Next cycle: REN=0, enable=1, `loaddata_WB`=0xDEADBEEF, `stall_cnt`=1.
- Store at addr 0x80, data 0x1234, with `dhit` arriving after 3 cycles -> WEN=1 with a stable address and data for 3 cycles, then DONE. `stall_cnt`=3 and `loaddata_WB` is unchanged.
- Redirect cases:
  - `PC_Src_MEM`=01, zero=1, `branch_addr`=0x100 -> `pc_redirect`=1, `pc_target`=0x100, both flushes=1.
  - With zero=0 -> all 0.
  - 11 with `busA`=0x200 -> target 0x200.
- `nRST` asserted while waiting on `dhit` for a load -> REN drops immediately. After release, with no op present, enable=1 and the FSM is IDLE.
- Both `memtoReg_MEM` and `memWr_MEM` set -> WEN=1, REN=0. Hold 2^CNT_W+5 stall cycles -> `stall_cnt` saturates at all-ones.
